adc_sample_ctrl: RTL and testbench
==================================

ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 The block SHALL have parameter LGFIFO, default 5, meaning log2 of sample FIFO depth (legal 2..7).
REQ-002 The block SHALL have parameter MINPER, default 16'd63, meaning the minimum effective sample period in clocks.
REQ-003 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  Wishbone bus cycle, strobe, write-enable.
REQ-006 i_wb_addr  input  1  register select: 0 = CTRL/STATUS, 1 = DATA.
REQ-007 i_wb_data  input  32  write data.
REQ-008 o_wb_stall, o_wb_ack  output  1 each  bus stall (tied 0) and acknowledge.
REQ-009 o_wb_data  output  32  read data.
REQ-010 o_adc_request, o_adc_en, o_adc_rd  output  1 each  request, enable and read-acknowledge to the SPI ADC sampler.
REQ-011 i_adc_data  input  14  sampler word: [13] = sampler idle/powered down, [12] = sample valid, [11:0] = sample.
REQ-012 o_int  output  1  FIFO half-full interrupt.

Function
REQ-013 Bus: o_wb_ack SHALL assert exactly one cycle after any cycle with i_wb_stb high, cleared while i_reset or !i_wb_cyc; o_wb_data SHALL be registered in the same cycle as the ack.
REQ-014 CTRL write: [15:0] -> period P, [16] -> enable request, [17] = 1 -> flush FIFO and clear overflow (self-clearing, not stored).
REQ-015 CTRL read: [31] overflow, [30] full, [29] empty, [27:20] fill count (zero-extended), [16] enable, [15:0] P; other bits 0.
REQ-016 DATA read: if FIFO non-empty, return {20'h0, oldest sample} and pop; if empty, return 32'h8000_0000, no pop; DATA writes ignored.
REQ-017 Effective period PE = max(P, MINPER); timer reloads to PE on expiry, giving one o_adc_request pulse every PE+1 clocks while in RUN.
REQ-018 Control FSM states: IDLE, RUN, SHUTDOWN.
REQ-019 IDLE -> RUN when enable = 1; first o_adc_request issues the cycle after entry; o_adc_en = 1 in RUN.
REQ-020 RUN -> SHUTDOWN when enable written 0; SHUTDOWN drives o_adc_en = 0, issues exactly one o_adc_request pulse, then -> IDLE when i_adc_data[13] = 1.
REQ-021 SHUTDOWN with enable rewritten 1 SHALL complete shutdown first, then IDLE -> RUN.
REQ-022 A write to P while in RUN SHALL take effect at the next timer reload.
REQ-023 Capture: when i_adc_data[12] = 1 and o_adc_rd was 0 the prior cycle, o_adc_rd SHALL pulse for one cycle and i_adc_data[11:0] SHALL be pushed in that same cycle; no sample pushed twice.
REQ-024 Push while full: sample dropped, overflow set (sticky until flush or reset); o_adc_rd still pulses.
REQ-025 Simultaneous push and pop: both occur, fill count unchanged; when full, pop frees the slot and the push succeeds.
REQ-026 Flush coincident with push: flush wins, FIFO empty afterwards.
REQ-027 FIFO pointers SHALL wrap modulo 2^LGFIFO; fill count width LGFIFO+1, range 0..2^LGFIFO.
REQ-028 o_int = 1 iff fill count >= 2^(LGFIFO-1), registered.

Reset
REQ-029 On i_reset: FSM IDLE, enable 0, P = 0, timer = 0, FIFO empty, overflow 0.
REQ-030 On i_reset: o_adc_request, o_adc_en, o_adc_rd, o_wb_ack, o_int all 0; o_wb_data 0.
REQ-031 Reset mid-RUN SHALL drop o_adc_en the next cycle without a shutdown request.

Verification
REQ-032 Write CTRL = 0x0001_0064 -> o_adc_request pulses every 101 clocks, o_adc_en = 1.
REQ-033 Write CTRL = 0x0001_0005 -> period clamps to MINPER: pulses every 64 clocks.
REQ-034 Hold i_adc_data[12] = 1 for 3 cycles with sample 0xABC -> one o_adc_rd pulse, one push; DATA read returns 0x0000_0ABC; next DATA read returns 0x8000_0000.
REQ-035 Push 33 samples (LGFIFO = 5) without reads -> full = 1, overflow = 1, o_int = 1 since the 16th push; CTRL write bit 17 -> empty = 1, overflow = 0, o_int = 0.
REQ-036 RUN, write enable = 0 -> one request with o_adc_en = 0, FSM to IDLE after i_adc_data[13] = 1; no further requests.
REQ-037 Push and DATA pop in the same cycle at fill 32 -> fill stays 32, no overflow.

Source files
------------

// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_ctrl
// Brief    : Wishbone-controlled periodic sample requester for an SPI ADC
//            sampler, with a sample FIFO and half-full interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_ctrl #(
    parameter int          LGFIFO = 5,
    parameter logic [15:0] MINPER = 16'd63
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_adc_request,
    output logic        o_adc_en,
    output logic        o_adc_rd,
    input  logic [13:0] i_adc_data,
    output logic        o_int
);
    localparam int              c_depth    = 1 << LGFIFO;
    localparam logic [LGFIFO:0] c_full_cnt = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [LGFIFO:0] c_half_cnt = {2'b01, {(LGFIFO-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_SHUTDOWN = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [15:0]       r_period, r_timer, w_period_eff;
    logic              r_enable, r_sd_sent, r_valid_prev, r_overflow;
    logic [11:0]       r_mem [0:c_depth-1];
    logic [LGFIFO-1:0] r_wr_ptr, r_rd_ptr;
    logic [LGFIFO:0]   r_fill, w_fill_next;
    logic [7:0]        w_fill8;
    logic [31:0]       w_status;
    logic              w_bus, w_ctrl_wr, w_flush, w_data_rd, w_empty, w_full;
    logic              w_pop, w_capture, w_push, w_req;
    logic              w_unused;

    assign w_bus        = i_wb_cyc && i_wb_stb;
    assign w_ctrl_wr    = w_bus && i_wb_we && !i_wb_addr;
    assign w_flush      = w_ctrl_wr && i_wb_data[17];
    assign w_data_rd    = w_bus && !i_wb_we && i_wb_addr;
    assign w_empty      = (r_fill == '0);
    assign w_full       = (r_fill == c_full_cnt);
    assign w_pop        = w_data_rd && !w_empty;
    // Take a sample only on the rising edge of valid, and never right after an ack
    assign w_capture    = i_adc_data[12] && !r_valid_prev && !o_adc_rd;
    assign w_push       = w_capture && (!w_full || w_pop) && !w_flush;
    assign w_period_eff = (r_period < MINPER) ? MINPER : r_period;
    assign w_fill8      = 8'(r_fill);
    assign w_status     = {r_overflow, w_full, w_empty, 1'b0, w_fill8, 3'b000, r_enable, r_period};
    assign o_wb_stall   = 1'b0;
    assign o_adc_en     = (r_state == S_RUN);
    assign w_unused     = &{1'b0, i_wb_data[31:18]};

    always_comb begin
        w_fill_next = r_fill;
        if (w_flush)
            w_fill_next = '0;
        else if (w_push && !w_pop)
            w_fill_next = r_fill + 1'b1;
        else if (w_pop && !w_push)
            w_fill_next = r_fill - 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_enable)
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                if (!r_enable)
                    w_state_next = S_SHUTDOWN;
                else if (r_timer == '0)
                    w_req = 1'b1;
            end
            S_SHUTDOWN: begin
                // One final request tells the sampler to power down
                if (!r_sd_sent)
                    w_req = 1'b1;
                else if (i_adc_data[13])
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_enable      <= 1'b0;
            r_period      <= '0;
            r_timer       <= '0;
            r_sd_sent     <= 1'b0;
            o_adc_request <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            o_adc_request <= w_req;
            r_sd_sent     <= (r_state == S_SHUTDOWN) && (r_sd_sent || w_req);
            if (w_ctrl_wr) begin
                r_period <= i_wb_data[15:0];
                r_enable <= i_wb_data[16];
            end
            if (r_state == S_RUN && r_enable) begin
                if (r_timer == '0)
                    r_timer <= w_period_eff;
                else
                    r_timer <= r_timer - 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_overflow   <= 1'b0;
            r_valid_prev <= 1'b0;
            o_adc_rd     <= 1'b0;
            o_int        <= 1'b0;
        end else begin
            r_valid_prev <= i_adc_data[12];
            o_adc_rd     <= w_capture;
            r_fill       <= w_fill_next;
            o_int        <= (w_fill_next >= c_half_cnt);
            if (w_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_capture && w_full && !w_pop)
                    r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_adc_data[11:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= w_bus;
            if (w_bus) begin
                if (!i_wb_addr)
                    o_wb_data <= w_status;
                else if (w_empty)
                    o_wb_data <= 32'h8000_0000;
                else
                    o_wb_data <= {20'h0, r_mem[r_rd_ptr]};
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_ctrl
// Brief    : Self-checking bench for adc_sample_ctrl with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_ctrl;
    localparam int DEPTH = 32;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0, i_wb_addr = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic [13:0] i_adc_data = 14'h2000;
    logic        o_wb_stall, o_wb_ack, o_adc_request, o_adc_en, o_adc_rd, o_int;
    logic [31:0] o_wb_data;

    adc_sample_ctrl #(.LGFIFO(5), .MINPER(16'd63)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .o_adc_request(o_adc_request), .o_adc_en(o_adc_en), .o_adc_rd(o_adc_rd),
        .i_adc_data(i_adc_data), .o_int(o_int)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0, n_err = 0, cyc = 0, t_last = 0, rd_cnt = 0;
    always @(posedge i_clk) cyc++;
    always @(negedge i_clk) if (!i_reset && o_adc_rd) rd_cnt++;

    // Reference model: FIFO contents, sticky overflow, control fields
    logic [11:0] q[$];
    logic        m_ovf = 1'b0, m_en = 1'b0;
    logic [15:0] m_per = '0;

    typedef struct {
        logic [31:0] wr;
        logic [31:0] exp;
    } ctrl_vec_t;
    ctrl_vec_t tbl[5];

    function automatic logic [31:0] model_status();
        int n = q.size();
        return {m_ovf, (n == DEPTH), (n == 0), 1'b0, 8'(n), 3'b000, m_en, m_per};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input bit we, input bit addr, input logic [31:0] wd,
                           input bit with_valid, input logic [11:0] smp, output logic [31:0] rd);
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr; i_wb_data = wd;
        if (with_valid) begin
            i_adc_data[12]   = 1'b1;
            i_adc_data[11:0] = smp;
        end
        @(posedge i_clk); #1;
        check("wb_ack", 32'(o_wb_ack), 32'd1);
        rd = o_wb_data;
        t_last = cyc;
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_adc_data[12] = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [31:0] d);
        logic [31:0] rd;
        wb_xfer(1'b1, 1'b0, d, 1'b0, 12'h0, rd);
        m_per = d[15:0];
        m_en  = d[16];
        if (d[17]) begin
            q.delete();
            m_ovf = 1'b0;
        end
    endtask

    task automatic chk_status(input string nm);
        logic [31:0] rd;
        wb_xfer(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, rd);
        check(nm, rd, model_status());
    endtask

    task automatic chk_data(input string nm);
        logic [31:0] rd, exp;
        if (q.size() > 0) exp = {20'h0, q.pop_front()};
        else              exp = 32'h8000_0000;
        wb_xfer(1'b0, 1'b1, 32'h0, 1'b0, 12'h0, rd);
        check(nm, rd, exp);
    endtask

    task automatic push(input logic [11:0] smp, input int hold);
        @(negedge i_clk);
        i_adc_data[12]   = 1'b1;
        i_adc_data[11:0] = smp;
        repeat (hold) @(negedge i_clk);
        i_adc_data[12] = 1'b0;
        @(negedge i_clk);
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else                   q.push_back(smp);
    endtask

    task automatic wait_req(input int maxc, output int t);
        t = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge i_clk); #1;
            if (o_adc_request) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout: no o_adc_request within %0d cycles", maxc);
        end
    endtask

    task automatic count_req(input int ncyc, output int c);
        c = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge i_clk); #1;
            if (o_adc_request) c++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, t4, c, rd_before;
        logic [31:0] rd, exp;

        tbl[0] = '{32'h0000_0064, 32'h2000_0064};
        tbl[1] = '{32'h0000_FFFF, 32'h2000_FFFF};
        tbl[2] = '{32'hFFFC_0005, 32'h2000_0005};
        tbl[3] = '{32'h0002_1234, 32'h2000_1234};
        tbl[4] = '{32'h0000_0000, 32'h2000_0000};

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_request", 32'(o_adc_request), 32'd0);
        check("rst_en",      32'(o_adc_en),      32'd0);
        check("rst_rd",      32'(o_adc_rd),      32'd0);
        check("rst_ack",     32'(o_wb_ack),      32'd0);
        check("rst_int",     32'(o_int),         32'd0);
        check("rst_wbdata",  o_wb_data,          32'h0);
        check("rst_stall",   32'(o_wb_stall),    32'd0);
        i_reset = 1'b0;
        chk_status("status_after_reset");

        // CTRL write/readback table
        foreach (tbl[i]) begin
            ctrl_wr(tbl[i].wr);
            wb_xfer(1'b0, 1'b0, 32'h0, 1'b0, 12'h0, rd);
            check($sformatf("ctrl_tbl[%0d]", i), rd, tbl[i].exp);
        end

        // Periodic requests: P=100 then clamped P=5
        i_adc_data[13] = 1'b0;
        ctrl_wr(32'h0001_0064);
        wait_req(10, t0);
        check("first_req_latency", 32'(t0 - t_last), 32'd2);
        @(posedge i_clk); #1;
        check("req_width", 32'(o_adc_request), 32'd0);
        wait_req(200, t1);
        check("period_101_a", 32'(t1 - t0), 32'd101);
        wait_req(200, t2);
        check("period_101_b", 32'(t2 - t1), 32'd101);
        check("en_in_run", 32'(o_adc_en), 32'd1);
        ctrl_wr(32'h0001_0005);
        wait_req(200, t3);
        check("period_change_at_reload", 32'(t3 - t2), 32'd101);
        wait_req(200, t4);
        check("period_clamped_a", 32'(t4 - t3), 32'd64);
        wait_req(200, t0);
        check("period_clamped_b", 32'(t0 - t4), 32'd64);

        // Shutdown with sampler still busy, re-enable during shutdown
        ctrl_wr(32'h0000_0005);
        wait_req(10, t1);
        check("shutdown_req_en", 32'(o_adc_en), 32'd0);
        ctrl_wr(32'h0001_0005);
        count_req(100, c);
        check("shutdown_no_extra_req", 32'(c), 32'd0);
        check("shutdown_en_low", 32'(o_adc_en), 32'd0);
        @(negedge i_clk);
        i_adc_data[13] = 1'b1;
        wait_req(10, t2);
        check("rerun_en", 32'(o_adc_en), 32'd1);
        wait_req(200, t3);
        check("rerun_period", 32'(t3 - t2), 32'd64);
        ctrl_wr(32'h0000_0005);
        wait_req(10, t4);
        check("shutdown2_req_en", 32'(o_adc_en), 32'd0);
        count_req(300, c);
        check("idle_no_req", 32'(c), 32'd0);
        chk_status("status_idle");

        // Single capture from a 3-cycle valid
        rd_before = rd_cnt;
        push(12'hABC, 3);
        check("rd_pulses_once", 32'(rd_cnt - rd_before), 32'd1);
        chk_data("data_abc");
        chk_data("data_empty");

        // Fill beyond capacity
        ctrl_wr(32'h0002_0000);
        for (int i = 0; i < 33; i++) begin
            push(12'($urandom), 1);
            if (i == 14) check("int_before_16", 32'(o_int), 32'd0);
            if (i == 15) check("int_at_16", 32'(o_int), 32'd1);
        end
        check("status_full_const", model_status(), 32'hC200_0000);
        chk_status("status_full_ovf");
        ctrl_wr(32'h0002_0000);
        chk_status("status_flushed");
        check("int_after_flush", 32'(o_int), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) push(12'(i * 37 + 5), 1);
        exp = {20'h0, q.pop_front()};
        q.push_back(12'h5A5);
        wb_xfer(1'b0, 1'b1, 32'h0, 1'b1, 12'h5A5, rd);
        check("pushpop_data", rd, exp);
        chk_status("pushpop_status");
        for (int i = 0; i < DEPTH; i++) chk_data("drain");
        chk_data("drain_empty");

        // Flush coincident with push
        push(12'h111, 1);
        wb_xfer(1'b1, 1'b0, 32'h0002_0000, 1'b1, 12'h777, rd);
        q.delete(); m_ovf = 1'b0; m_per = '0; m_en = 1'b0;
        chk_status("flush_wins");
        chk_data("flush_wins_data");

        // Randomized mix against the model
        for (int it = 0; it < 150; it++) begin
            int op = $urandom_range(0, 9);
            if (op <= 4)      push(12'($urandom), $urandom_range(1, 3));
            else if (op <= 6) chk_data("rand_data");
            else if (op == 9 && $urandom_range(0, 3) == 0) ctrl_wr(32'h0002_0000);
            else              chk_status("rand_status");
            check("rand_int", 32'(o_int), 32'(q.size() >= DEPTH / 2));
        end
        chk_status("rand_final_status");

        // Reset in the middle of RUN
        ctrl_wr(32'h0001_0000);
        wait_req(10, t0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        check("midrun_rst_en", 32'(o_adc_en), 32'd0);
        check("midrun_rst_req", 32'(o_adc_request), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        q.delete(); m_ovf = 1'b0; m_per = '0; m_en = 1'b0;
        count_req(200, c);
        check("midrun_rst_no_req", 32'(c), 32'd0);
        chk_status("midrun_rst_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
